enable_reg_arbiter: RTL and testbench

Shares one clock-enabled register (the `Register` datapath: data `I`, enable `CE`, value `O`) among `N_REQ` requesters. Uses round-robin arbitration with a valid/ready handshake. Supports read-modify-write ops (write/set/clear/toggle), computed from an internal shadow copy of the register value. It is the sole writer of the register and drives the register's `I`/`CE` from registered outputs.

---
 rtl/enable_reg_arb_pkg.sv | 35 +++
 rtl/enable_reg_arbiter_rr_pick.sv | 40 ++++
 rtl/enable_reg_arbiter.sv | 115 +++++++++++
 tb/tb_enable_reg_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/enable_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enable_reg_arb_pkg
// Description : Shared types, constants and the read-modify-write helper
//               for enable_reg_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package enable_reg_arb_pkg;

  localparam int OP_W      = 2;
  localparam int DEF_WIDTH = 8;
  // Widest register the helper supports; callers cast in and out.
  localparam int MAX_W     = 64;

  typedef enum logic [OP_W-1:0] {
    WRITE  = 2'd0,
    SET    = 2'd1,
    CLR    = 2'd2,
    TOGGLE = 2'd3
  } op_e;

  function automatic logic [MAX_W-1:0] apply_op(input op_e op,
                                                input logic [MAX_W-1:0] shadow,
                                                input logic [MAX_W-1:0] data);
    case (op)
      WRITE:   return data;
      SET:     return shadow | data;
      CLR:     return shadow & ~data;
      TOGGLE:  return shadow ^ data;
      default: return data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/enable_reg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; priority starts one past
//               i_ptr and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PW-1:0]    o_idx
);

  int               w_cand;
  logic             w_found;
  logic [N_REQ-1:0] w_shift;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    w_shift = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand  = (int'(i_ptr) + k) % N_REQ;
      w_shift = i_req >> w_cand;
      if (!w_found && w_shift[0]) begin
        w_found = 1'b1;
        o_gnt   = N_REQ'(1) << w_cand;
        o_idx   = PW'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enable_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : enable_reg_arbiter
// Description : Round-robin valid/ready arbiter driving one clock-enabled
//               register with RMW ops; optional grant lock via
//               ENABLE_REG_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module enable_reg_arbiter
  import enable_reg_arb_pkg::*;
#(
  parameter int               N_REQ = 4,
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = 8'hDE
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_op,
  input  logic [WIDTH*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        req_ready,
  output logic [WIDTH-1:0]        reg_I,
  output logic                    reg_CE,
  output logic [WIDTH-1:0]        value
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_reg_I;
  logic             r_reg_CE;

  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_xfer;
  logic [OP_W-1:0]  w_sel_op;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_nv;

`ifdef ENABLE_REG_ARBITER_LOCK_EN
  logic             r_locked;
  logic [PW-1:0]    r_lock_idx;
  logic             w_lock_sel;

  // While locked only the owner may be considered by the picker.
  assign w_req_eff  = r_locked ? (req_valid & (N_REQ'(1) << r_lock_idx)) : req_valid;
  assign w_lock_sel = |(req_lock & req_ready);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      r_locked   <= w_lock_sel;
      r_lock_idx <= w_idx;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_req_eff     = req_valid;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .i_req (w_req_eff),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign req_ready = RESET ? '0 : w_gnt;
  assign w_xfer    = |req_ready;

  always_comb begin
    w_sel_op   = '0;
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_idx == PW'(k)) begin
        w_sel_op   = req_op[k*OP_W +: OP_W];
        w_sel_data = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Operate on the shadow, not the register output, so back-to-back RMW is safe.
  assign w_nv = WIDTH'(apply_op(op_e'(w_sel_op), MAX_W'(r_shadow), MAX_W'(w_sel_data)));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr    <= PW'(N_REQ - 1);
      r_shadow <= INIT;
      r_reg_I  <= INIT;
      r_reg_CE <= 1'b0;
    end else begin
      r_reg_CE <= w_xfer;
      if (w_xfer) begin
        r_ptr    <= w_idx;
        r_shadow <= w_nv;
        r_reg_I  <= w_nv;
      end
    end
  end

  assign reg_I  = r_reg_I;
  assign reg_CE = r_reg_CE;
  assign value  = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_enable_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_enable_reg_arbiter
// Description : Table-driven self-checking bench for enable_reg_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enable_reg_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [7:0]  reg_I;
  logic        reg_CE;
  logic [7:0]  value;

  int n_cmp = 0;
  int n_bad = 0;

  enable_reg_arbiter #(
    .N_REQ (4),
    .WIDTH (8),
    .INIT  (8'hDE)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .reg_I     (reg_I),
    .reg_CE    (reg_CE),
    .value     (value)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [7:0]  op;
    logic [31:0] d;
    logic [3:0]  lk;
    logic [3:0]  rdy;
    logic        ce;
    logic [7:0]  i;
    logic [7:0]  val;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] v, input logic [7:0] op,
                     input logic [31:0] d, input logic [3:0] lk, input logic [3:0] rdy,
                     input logic ce, input logic [7:0] i, input logic [7:0] val);
    vec_t t;
    t.rst = rst; t.v = v; t.op = op; t.d = d; t.lk = lk;
    t.rdy = rdy; t.ce = ce; t.i = i; t.val = val;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"}, 32'(req_ready), 32'h0);
    chk({tag, " CE"},    32'(reg_CE),    32'h0);
    chk({tag, " reg_I"}, 32'(reg_I),     32'hDE);
    chk({tag, " value"}, 32'(value),     32'hDE);
  endtask

  initial begin
    // ---------------- vector table ----------------
    // single write then idle
    add(0, 4'b0001, 8'h00, 32'h0000005A, 4'h0, 4'b0001, 1, 8'h5A, 8'h5A);
    add(0, 4'b0000, 8'h00, 32'h0000005A, 4'h0, 4'b0000, 0, 8'h5A, 8'h5A);
    // park pointer on requester 3
    add(0, 4'b1000, 8'h00, 32'h77000000, 4'h0, 4'b1000, 1, 8'h77, 8'h77);
    // contention: all four, each drops after its grant
    add(0, 4'b1111, 8'h00, 32'h44332211, 4'h0, 4'b0001, 1, 8'h11, 8'h11);
    add(0, 4'b1110, 8'h00, 32'h44332211, 4'h0, 4'b0010, 1, 8'h22, 8'h22);
    add(0, 4'b1100, 8'h00, 32'h44332211, 4'h0, 4'b0100, 1, 8'h33, 8'h33);
    add(0, 4'b1000, 8'h00, 32'h44332211, 4'h0, 4'b1000, 1, 8'h44, 8'h44);
    add(0, 4'b0000, 8'h00, 32'h44332211, 4'h0, 4'b0000, 0, 8'h44, 8'h44);
    // back-to-back RMW from reset value DE
    add(1, 4'b0010, 8'h04, 32'h00000100, 4'h0, 4'b0010, 1, 8'hDF, 8'hDF);
    add(0, 4'b0100, 8'h20, 32'h00C00000, 4'h0, 4'b0100, 1, 8'h1F, 8'h1F);
    add(0, 4'b1000, 8'hC0, 32'hFF000000, 4'h0, 4'b1000, 1, 8'hE0, 8'hE0);
    // req0 WRITE 0F vs req2 SET F0 with ptr=3
    add(0, 4'b0101, 8'h10, 32'h00F0000F, 4'h0, 4'b0001, 1, 8'h0F, 8'h0F);
    add(0, 4'b0100, 8'h10, 32'h00F0000F, 4'h0, 4'b0100, 1, 8'hFF, 8'hFF);
    add(0, 4'b0000, 8'h00, 32'h00000000, 4'h0, 4'b0000, 0, 8'hFF, 8'hFF);
    // lock sequence
    add(1, 4'b0100, 8'h00, 32'h00100000, 4'b0100, 4'b0100, 1, 8'h10, 8'h10);
`ifdef ENABLE_REG_ARBITER_LOCK_EN
    add(0, 4'b0001, 8'h00, 32'h000000AA, 4'h0, 4'b0000, 0, 8'h10, 8'h10);
    add(0, 4'b0101, 8'h00, 32'h002000AA, 4'h0, 4'b0100, 1, 8'h20, 8'h20);
    add(0, 4'b0001, 8'h00, 32'h000000AA, 4'h0, 4'b0001, 1, 8'hAA, 8'hAA);
`else
    add(0, 4'b0101, 8'h00, 32'h002000AA, 4'h0, 4'b0001, 1, 8'hAA, 8'hAA);
    add(0, 4'b0100, 8'h00, 32'h00200000, 4'h0, 4'b0100, 1, 8'h20, 8'h20);
    add(0, 4'b0000, 8'h00, 32'h00000000, 4'h0, 4'b0000, 0, 8'h20, 8'h20);
`endif

    // ---------------- power-on reset, valid held high ----------------
    RESET = 1'b1; req_valid = 4'b0001; req_op = '0; req_data = '0; req_lock = '0;
    #2;
    chk_reset_outputs("por");
    @(negedge CLK);
    req_valid = '0;
    RESET     = 1'b0;

    // ---------------- table ----------------
    foreach (tbl[n]) begin
      @(negedge CLK);
      if (tbl[n].rst) begin
        RESET = 1'b1;
        #1;
        chk_reset_outputs($sformatf("v%0d rst", n));
        #1;
        RESET = 1'b0;
      end
      req_valid = tbl[n].v;
      req_op    = tbl[n].op;
      req_data  = tbl[n].d;
      req_lock  = tbl[n].lk;
      #1;
      chk($sformatf("v%0d ready", n), 32'(req_ready), 32'(tbl[n].rdy));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d CE", n),    32'(reg_CE), 32'(tbl[n].ce));
      chk($sformatf("v%0d reg_I", n), 32'(reg_I),  32'(tbl[n].i));
      chk($sformatf("v%0d value", n), 32'(value),  32'(tbl[n].val));
    end

    // ---------------- reset while req1 is in flight ----------------
    @(negedge CLK);
    req_valid = 4'b0010; req_op = 8'h00; req_data = 32'h00003C00; req_lock = '0;
    #1;
    chk("mid accept ready", 32'(req_ready), 32'h2);
    #1;
    RESET = 1'b1;
    #1;
    chk_reset_outputs("mid async");
    @(posedge CLK);
    #1;
    chk("mid dropped CE",    32'(reg_CE), 32'h0);
    chk("mid dropped value", 32'(value),  32'hDE);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("mid re-present ready", 32'(req_ready), 32'h2);
    @(posedge CLK);
    #1;
    chk("mid re-present CE",    32'(reg_CE), 32'h1);
    chk("mid re-present value", 32'(value),  32'h3C);
    @(negedge CLK);
    req_valid = '0;
    @(posedge CLK);
    #1;
    chk("final idle CE", 32'(reg_CE), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
